// File: rtl/mem_access_ctrl_if.sv
// Data-bus handshake between the memory-stage access sequencer and data memory.
// One request is outstanding at a time; dresp_ready is a single-cycle acknowledge.
interface mem_access_ctrl_if;
  logic        dreq_valid;
  logic        dreq_write;
  logic [31:0] dreq_addr;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_wdata;
  logic        dresp_ready;
  logic [31:0] dresp_data;

  modport master (
    output dreq_valid, dreq_write, dreq_addr, dreq_strobe, dreq_wdata,
    input  dresp_ready, dresp_data
  );

  modport slave (
    input  dreq_valid, dreq_write, dreq_addr, dreq_strobe, dreq_wdata,
    output dresp_ready, dresp_data
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MIPS memory-stage data access sequencer: one bus transaction per load/store,
// pipeline stall until acknowledge or timeout, load alignment/extension and store strobes.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 valid_i,
  input  logic                 flush_i,
  input  logic                 mem_read_i,
  input  logic                 mem_write_i,
  input  logic [1:0]           size_i,
  input  logic                 unsigned_i,
  input  logic [31:0]          addr_i,
  input  logic [31:0]          wdata_i,
  mem_access_ctrl_if.master    bus,
  output logic                 stall_o,
  output logic                 done_o,
  output logic [31:0]          rdata_o,
  output logic                 misalign_o,
  output logic                 timeout_o
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             flushed;
  logic [1:0]       lane_q;
  logic [1:0]       size_q;
  logic             uns_q;
  logic             is_load_q;

  logic       access;
  logic       is_half;
  logic       is_word;
  logic       misaligned;
  logic [3:0] strobe_c;
  logic [31:0] wdata_c;

  // Byte/half select on the registered lane, then sign or zero extension.
  function automatic logic [31:0] align_load(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [1:0]  size,
                                             input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(word >> {lane, 3'b000});
    h = 16'(word >> {lane[1], 4'b0000});
    case (size)
      2'd0:    r = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'd1:    r = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  assign access     = valid_i & (mem_read_i | mem_write_i) & ~flush_i;
  assign is_half    = (size_i == 2'd1);
  assign is_word    = size_i[1];
  assign misaligned = (is_half & addr_i[0]) | (is_word & (addr_i[1:0] != 2'b00));

  // Combinational so the pipeline freezes in the same cycle the access appears.
  assign stall_o    = access & ~misaligned & (state != S_DONE);
  assign misalign_o = access & misaligned;

  always_comb begin
    strobe_c = 4'b0000;
    wdata_c  = 32'd0;
    if (mem_write_i) begin
      case (size_i)
        2'd0: begin
          strobe_c = 4'b0001 << addr_i[1:0];
          wdata_c  = {4{wdata_i[7:0]}};
        end
        2'd1: begin
          strobe_c = 4'b0011 << addr_i[1:0];
          wdata_c  = {2{wdata_i[15:0]}};
        end
        default: begin
          strobe_c = 4'b1111;
          wdata_c  = wdata_i;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state           <= S_IDLE;
      wait_cnt        <= '0;
      flushed         <= 1'b0;
      lane_q          <= 2'd0;
      size_q          <= 2'd0;
      uns_q           <= 1'b0;
      is_load_q       <= 1'b0;
      bus.dreq_valid  <= 1'b0;
      bus.dreq_write  <= 1'b0;
      bus.dreq_addr   <= 32'd0;
      bus.dreq_strobe <= 4'd0;
      bus.dreq_wdata  <= 32'd0;
      done_o          <= 1'b0;
      timeout_o       <= 1'b0;
      rdata_o         <= 32'd0;
    end else begin
      done_o    <= 1'b0;
      timeout_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (access && !misaligned) begin
            state           <= S_REQ;
            wait_cnt        <= '0;
            flushed         <= 1'b0;
            lane_q          <= addr_i[1:0];
            size_q          <= size_i;
            uns_q           <= unsigned_i;
            is_load_q       <= mem_read_i;
            bus.dreq_valid  <= 1'b1;
            bus.dreq_write  <= mem_write_i;
            bus.dreq_addr   <= {addr_i[31:2], 2'b00};
            bus.dreq_strobe <= strobe_c;
            bus.dreq_wdata  <= wdata_c;
          end
        end
        S_REQ: begin
          // A flushed access still waits out the bus, then vanishes without done_o.
          if (bus.dresp_ready) begin
            bus.dreq_valid <= 1'b0;
            if (flushed || flush_i) begin
              state <= S_IDLE;
            end else begin
              state   <= S_DONE;
              done_o  <= 1'b1;
              rdata_o <= is_load_q ? align_load(bus.dresp_data, lane_q, size_q, uns_q) : 32'd0;
            end
          end else if (wait_cnt == CNT_LAST) begin
            bus.dreq_valid <= 1'b0;
            if (flushed || flush_i) begin
              state <= S_IDLE;
            end else begin
              state     <= S_DONE;
              done_o    <= 1'b1;
              timeout_o <= 1'b1;
              rdata_o   <= 32'd0;
            end
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
            if (flush_i) flushed <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state          <= S_IDLE;
          bus.dreq_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl (TIMEOUT = 4).
module tb_mem_access_ctrl;

  logic        clk;
  logic        resetn;
  logic        valid_i;
  logic        flush_i;
  logic        mem_read_i;
  logic        mem_write_i;
  logic [1:0]  size_i;
  logic        unsigned_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        stall_o;
  logic        done_o;
  logic [31:0] rdata_o;
  logic        misalign_o;
  logic        timeout_o;

  int total;
  int bad;

  mem_access_ctrl_if bus_if ();

  mem_access_ctrl #(.TIMEOUT(4)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .valid_i     (valid_i),
    .flush_i     (flush_i),
    .mem_read_i  (mem_read_i),
    .mem_write_i (mem_write_i),
    .size_i      (size_i),
    .unsigned_i  (unsigned_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .bus         (bus_if),
    .stall_o     (stall_o),
    .done_o      (done_o),
    .rdata_o     (rdata_o),
    .misalign_o  (misalign_o),
    .timeout_o   (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    valid_i            = 1'b0;
    flush_i            = 1'b0;
    mem_read_i         = 1'b0;
    mem_write_i        = 1'b0;
    size_i             = 2'd0;
    unsigned_i         = 1'b0;
    addr_i             = 32'd0;
    wdata_i            = 32'd0;
    bus_if.dresp_ready = 1'b0;
    bus_if.dresp_data  = 32'd0;
  endtask

  // Full access with 'waits' bus wait cycles; checks request fields, stall length and result.
  task automatic run_access(input string nm, input logic rd, input logic wr,
                            input logic [1:0] sz, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input int waits, input logic [31:0] bus_data,
                            input logic [3:0] exp_strobe, input logic [31:0] exp_wdata,
                            input logic [31:0] exp_rdata);
    int stalls;
    logic [31:0] exp_addr;
    exp_addr = {addr[31:2], 2'b00};
    stalls = 0;
    valid_i = 1'b1; mem_read_i = rd; mem_write_i = wr;
    size_i = sz; unsigned_i = uns; addr_i = addr; wdata_i = wd;
    #1;
    total++;
    if (stall_o !== 1'b1 || bus_if.dreq_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s cycle0: stall=%b dreq_valid=%b required stall=1 dreq_valid=0", nm, stall_o, bus_if.dreq_valid);
    end
    if (stall_o === 1'b1) stalls++;
    step();
    total++;
    if (bus_if.dreq_valid !== 1'b1 || bus_if.dreq_addr !== exp_addr ||
        bus_if.dreq_strobe !== exp_strobe || bus_if.dreq_wdata !== exp_wdata ||
        bus_if.dreq_write !== wr) begin
      bad++;
      $display("FAIL %s request: valid=%b addr=%h strobe=%b wdata=%h write=%b required 1 %h %b %h %b",
               nm, bus_if.dreq_valid, bus_if.dreq_addr, bus_if.dreq_strobe, bus_if.dreq_wdata,
               bus_if.dreq_write, exp_addr, exp_strobe, exp_wdata, wr);
    end
    for (int w = 0; w < waits; w++) begin
      if (stall_o === 1'b1) stalls++;
      step();
      total++;
      if (bus_if.dreq_valid !== 1'b1 || bus_if.dreq_addr !== exp_addr) begin
        bad++;
        $display("FAIL %s wait%0d: valid=%b addr=%h required 1 %h", nm, w, bus_if.dreq_valid, bus_if.dreq_addr, exp_addr);
      end
    end
    bus_if.dresp_ready = 1'b1;
    bus_if.dresp_data  = bus_data;
    #1;
    if (stall_o === 1'b1) stalls++;
    step();
    bus_if.dresp_ready = 1'b0;
    bus_if.dresp_data  = 32'd0;
    total++;
    if (done_o !== 1'b1 || stall_o !== 1'b0 || timeout_o !== 1'b0 ||
        rdata_o !== exp_rdata || bus_if.dreq_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s done: done=%b stall=%b timeout=%b rdata=%h valid=%b required 1 0 0 %h 0",
               nm, done_o, stall_o, timeout_o, rdata_o, bus_if.dreq_valid, exp_rdata);
    end
    total++;
    if (stalls !== 2 + waits) begin
      bad++;
      $display("FAIL %s stall_cycles: got %0d required %0d", nm, stalls, 2 + waits);
    end
    valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
    step();
    total++;
    if (done_o !== 1'b0 || bus_if.dreq_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s after: done=%b valid=%b required 0 0", nm, done_o, bus_if.dreq_valid);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    resetn = 1'b0;
    step();
    step();
    total++;
    if (bus_if.dreq_valid !== 1'b0 || bus_if.dreq_write !== 1'b0 || bus_if.dreq_addr !== 32'd0 ||
        bus_if.dreq_strobe !== 4'd0 || bus_if.dreq_wdata !== 32'd0 || done_o !== 1'b0 ||
        timeout_o !== 1'b0 || rdata_o !== 32'd0 || stall_o !== 1'b0 || misalign_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_values: valid=%b write=%b addr=%h strobe=%b wdata=%h done=%b to=%b rdata=%h stall=%b mis=%b required all zero",
               bus_if.dreq_valid, bus_if.dreq_write, bus_if.dreq_addr, bus_if.dreq_strobe,
               bus_if.dreq_wdata, done_o, timeout_o, rdata_o, stall_o, misalign_o);
    end
    resetn = 1'b1;
    bus_if.dresp_ready = 1'b1;
    bus_if.dresp_data  = 32'h1234_5678;
    step();
    step();
    total++;
    if (done_o !== 1'b0 || bus_if.dreq_valid !== 1'b0 || rdata_o !== 32'd0) begin
      bad++;
      $display("FAIL stray_ack: done=%b valid=%b rdata=%h required 0 0 0", done_o, bus_if.dreq_valid, rdata_o);
    end
    bus_if.dresp_ready = 1'b0;
    bus_if.dresp_data  = 32'd0;
  endtask

  task automatic test_loads();
    run_access("lw_100", 1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'd0, 0, 32'hDEAD_BEEF,
               4'b0000, 32'd0, 32'hDEAD_BEEF);
    run_access("lbu_203", 1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_0203, 32'd0, 0, 32'h8012_3456,
               4'b0000, 32'd0, 32'h0000_0080);
    run_access("lb_203", 1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0203, 32'd0, 0, 32'h8012_3456,
               4'b0000, 32'd0, 32'hFFFF_FF80);
    run_access("lh_202", 1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_0202, 32'd0, 2, 32'hBEEF_1234,
               4'b0000, 32'd0, 32'hFFFF_BEEF);
    run_access("lhu_200", 1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_0200, 32'd0, 1, 32'hBEEF_9234,
               4'b0000, 32'd0, 32'h0000_9234);
    run_access("lb_201", 1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0201, 32'd0, 0, 32'h0000_7F00,
               4'b0000, 32'd0, 32'h0000_007F);
  endtask

  task automatic test_stores();
    run_access("sb_203", 1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_0203, 32'h0000_00A5, 0, 32'hFFFF_FFFF,
               4'b1000, 32'hA5A5_A5A5, 32'd0);
    run_access("sh_102", 1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_0102, 32'h1234_ABCD, 1, 32'd0,
               4'b1100, 32'hABCD_ABCD, 32'd0);
    run_access("sw_ill3", 1'b0, 1'b1, 2'd3, 1'b0, 32'h0000_0400, 32'h0BAD_CAFE, 0, 32'd0,
               4'b1111, 32'h0BAD_CAFE, 32'd0);
  endtask

  task automatic test_back_to_back();
    run_access("b2b_first", 1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'd0, 0, 32'h1111_1111,
               4'b0000, 32'd0, 32'h1111_1111);
    run_access("b2b_second", 1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_0015, 32'h0000_003C, 0, 32'd0,
               4'b0010, 32'h3C3C_3C3C, 32'd0);
  endtask

  task automatic test_misalign();
    logic [31:0] a [2];
    logic [1:0]  s [2];
    a[0] = 32'h0000_0101; s[0] = 2'd1;
    a[1] = 32'h0000_0102; s[1] = 2'd2;
    for (int i = 0; i < 2; i++) begin
      valid_i = 1'b1; mem_read_i = 1'b1; size_i = s[i]; addr_i = a[i];
      #1;
      total++;
      if (misalign_o !== 1'b1 || stall_o !== 1'b0) begin
        bad++;
        $display("FAIL misalign_%0d: misalign=%b stall=%b required 1 0", i, misalign_o, stall_o);
      end
      step();
      step();
      total++;
      if (bus_if.dreq_valid !== 1'b0 || done_o !== 1'b0) begin
        bad++;
        $display("FAIL misalign_bus_%0d: valid=%b done=%b required 0 0", i, bus_if.dreq_valid, done_o);
      end
    end
    size_i = 2'd1; addr_i = 32'h0000_0102;
    flush_i = 1'b1;
    #1;
    total++;
    if (misalign_o !== 1'b0 || stall_o !== 1'b0) begin
      bad++;
      $display("FAIL flushed_idle: misalign=%b stall=%b required 0 0", misalign_o, stall_o);
    end
    step();
    total++;
    if (bus_if.dreq_valid !== 1'b0) begin
      bad++;
      $display("FAIL flushed_idle_bus: valid=%b required 0", bus_if.dreq_valid);
    end
    clear_inputs();
    step();
  endtask

  task automatic test_timeout();
    int n;
    valid_i = 1'b1; mem_read_i = 1'b1; size_i = 2'd2; addr_i = 32'h0000_0300;
    step();
    n = 0;
    while (bus_if.dreq_valid === 1'b1 && n < 20) begin
      n++;
      step();
    end
    total++;
    if (n !== 4 || done_o !== 1'b1 || timeout_o !== 1'b1 || rdata_o !== 32'd0) begin
      bad++;
      $display("FAIL timeout: req_cycles=%0d done=%b timeout=%b rdata=%h required 4 1 1 0",
               n, done_o, timeout_o, rdata_o);
    end
    clear_inputs();
    step();
    total++;
    if (done_o !== 1'b0 || timeout_o !== 1'b0) begin
      bad++;
      $display("FAIL timeout_clear: done=%b timeout=%b required 0 0", done_o, timeout_o);
    end
  endtask

  task automatic test_flush();
    valid_i = 1'b1; mem_read_i = 1'b1; size_i = 2'd2; addr_i = 32'h0000_0400;
    step();
    step();
    flush_i = 1'b1;
    #1;
    total++;
    if (bus_if.dreq_valid !== 1'b1 || stall_o !== 1'b0) begin
      bad++;
      $display("FAIL flush_req2: valid=%b stall=%b required 1 0", bus_if.dreq_valid, stall_o);
    end
    step();
    flush_i = 1'b0;
    total++;
    if (bus_if.dreq_valid !== 1'b1 || bus_if.dreq_addr !== 32'h0000_0400) begin
      bad++;
      $display("FAIL flush_held: valid=%b addr=%h required 1 00000400", bus_if.dreq_valid, bus_if.dreq_addr);
    end
    valid_i = 1'b0;
    bus_if.dresp_ready = 1'b1;
    bus_if.dresp_data  = 32'h5555_AAAA;
    step();
    bus_if.dresp_ready = 1'b0;
    total++;
    if (bus_if.dreq_valid !== 1'b0 || done_o !== 1'b0) begin
      bad++;
      $display("FAIL flush_drop: valid=%b done=%b required 0 0", bus_if.dreq_valid, done_o);
    end
    step();
    total++;
    if (done_o !== 1'b0 || bus_if.dreq_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_idle: done=%b valid=%b required 0 0", done_o, bus_if.dreq_valid);
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_req();
    run_access("pre_rst", 1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0020, 32'd0, 0, 32'h7777_8888,
               4'b0000, 32'd0, 32'h7777_8888);
    valid_i = 1'b1; mem_write_i = 1'b1; size_i = 2'd2;
    addr_i = 32'h0000_0500; wdata_i = 32'hCAFE_F00D;
    step();
    total++;
    if (bus_if.dreq_valid !== 1'b1) begin
      bad++;
      $display("FAIL rst_setup: valid=%b required 1", bus_if.dreq_valid);
    end
    resetn = 1'b0;
    valid_i = 1'b0;
    step();
    total++;
    if (bus_if.dreq_valid !== 1'b0 || bus_if.dreq_write !== 1'b0 || bus_if.dreq_addr !== 32'd0 ||
        bus_if.dreq_strobe !== 4'd0 || bus_if.dreq_wdata !== 32'd0 || rdata_o !== 32'd0 ||
        done_o !== 1'b0 || timeout_o !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_req: valid=%b write=%b addr=%h strobe=%b wdata=%h rdata=%h done=%b to=%b required all zero",
               bus_if.dreq_valid, bus_if.dreq_write, bus_if.dreq_addr, bus_if.dreq_strobe,
               bus_if.dreq_wdata, rdata_o, done_o, timeout_o);
    end
    resetn = 1'b1;
    clear_inputs();
    step();
    run_access("post_rst", 1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_0032, 32'd0, 0, 32'h00C3_0000,
               4'b0000, 32'd0, 32'h0000_00C3);
  endtask

  initial begin
    total = 0;
    bad = 0;
    resetn = 1'b0;
    clear_inputs();
    test_reset();
    test_loads();
    test_stores();
    test_back_to_back();
    test_misalign();
    test_timeout();
    test_flush();
    test_reset_mid_req();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
